// File: rtl/cam_capture_ctrl_if.sv
// Camera pin bundle and framebuffer write port shared by the capture engine and its environment.
// The slave side is the capture engine: it consumes camera pins and drives the write port.
interface cam_capture_ctrl_if #(
  parameter int AW    = 15,
  parameter int OUT_W = 12
);
  logic             vsync;
  logic             href;
  logic [7:0]       d;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [OUT_W-1:0] wdata;

  modport master (output vsync, href, d, input we, waddr, wdata);
  modport slave  (input vsync, href, d, output we, waddr, wdata);
endinterface

// File: rtl/cam_capture_ctrl.sv
// OV7670-style capture engine: pairs RGB565 bytes, decimates, packs to RGB111/332/444 and
// writes a row-major framebuffer, with single-shot/continuous arming, abort and short-frame flag.
module cam_capture_ctrl #(
  parameter int AW    = 15,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int DEC   = 1,
  parameter int OUT_W = 12
) (
  input  logic                 pclk,
  input  logic                 rst,
  cam_capture_ctrl_if.slave    bus,
  input  logic                 arm,
  input  logic                 cont,
  input  logic                 abort,
  input  logic [1:0]           mode,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 short_frame
);
  localparam int CW = $clog2(IMG_W + 1);
  localparam int LW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] IMG_W_C = CW'(IMG_W);
  localparam logic [LW-1:0] IMG_H_C = LW'(IMG_H);
  localparam logic [AW:0]   LINE_STEP = (AW+1)'(IMG_W);
  localparam logic [AW:0]   TOTAL = (AW+1)'(IMG_W * IMG_H);
  localparam logic [2:0]    DEC_LAST = 3'(DEC - 1);

  typedef enum logic [2:0] {IDLE, WAIT_VS, WAIT_ACT, CAPTURE, DONE} state_t;
  state_t state, state_next;

  logic             phase;
  logic             href_d;
  logic [6:0]       b0;
  logic [2:0]       col_ph;
  logic [2:0]       line_ph;
  logic [CW-1:0]    stored_col;
  logic [LW-1:0]    stored_line;
  logic [AW:0]      line_base;
  logic [AW:0]      wr_count;
  logic [AW:0]      addr_sum;
  logic [1:0]       mode_q;
  logic             we_q;
  logic [AW-1:0]    waddr_q;
  logic [OUT_W-1:0] wdata_q;
  logic             frame_done_q;
  logic             short_q;
  logic [11:0]      pix;
  logic             start, cap, line_keep, pix_keep, frame_end;

  always_ff @(posedge pclk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    cap        = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE:     if (arm) state_next = WAIT_VS;
      WAIT_VS:  if (bus.vsync) state_next = WAIT_ACT;
      WAIT_ACT: if (!bus.vsync) begin
                  state_next = CAPTURE;
                  start      = 1'b1;
                end
      CAPTURE:  if (bus.vsync) begin
                  state_next = DONE;
                  frame_end  = 1'b1;
                end else begin
                  cap = 1'b1;
                end
      DONE:     state_next = cont ? WAIT_ACT : IDLE;
      default:  state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      start      = 1'b0;
      cap        = 1'b0;
      frame_end  = 1'b0;
    end
  end

  // Decimation phases stand in for cam_col % DEC and cam_line % DEC without dividers.
  assign line_keep = (line_ph == 3'd0) && (stored_line < IMG_H_C);
  assign pix_keep  = cap && bus.href && phase && (col_ph == 3'd0) && line_keep
                     && (stored_col < IMG_W_C);
  assign addr_sum  = line_base + (AW+1)'(stored_col);

  // b0 keeps only {R4..R1, G5..G3}; R0 is never used by any format.
  always_comb begin
    case (mode_q)
      2'd1:    pix = {4'b0, b0[6:4], b0[2:0], bus.d[4:3]};
      2'd2:    pix = {b0[6:3], b0[2:0], bus.d[7], bus.d[4:1]};
      default: pix = {9'b0, b0[6], b0[2], bus.d[4]};
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      phase        <= 1'b0;
      href_d       <= 1'b0;
      b0           <= '0;
      col_ph       <= '0;
      line_ph      <= '0;
      stored_col   <= '0;
      stored_line  <= '0;
      line_base    <= '0;
      wr_count     <= '0;
      mode_q       <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      frame_done_q <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      if (state == IDLE && state_next == WAIT_VS) short_q <= 1'b0;
      if (start) begin
        mode_q      <= mode;
        phase       <= 1'b0;
        href_d      <= 1'b0;
        col_ph      <= '0;
        line_ph     <= '0;
        stored_col  <= '0;
        stored_line <= '0;
        line_base   <= '0;
        wr_count    <= '0;
      end
      if (cap) begin
        href_d <= bus.href;
        if (bus.href) begin
          phase <= ~phase;
          if (!phase) begin
            b0 <= {bus.d[7:4], bus.d[2:0]};
          end else begin
            col_ph <= (col_ph == DEC_LAST) ? 3'd0 : col_ph + 3'd1;
            if (pix_keep) begin
              we_q       <= 1'b1;
              waddr_q    <= addr_sum[AW-1:0];
              wdata_q    <= OUT_W'(pix);
              stored_col <= stored_col + 1'b1;
              wr_count   <= wr_count + 1'b1;
            end
          end
        end else begin
          phase <= 1'b0;
          if (href_d) begin
            col_ph     <= '0;
            stored_col <= '0;
            line_ph    <= (line_ph == DEC_LAST) ? 3'd0 : line_ph + 3'd1;
            if (line_keep) begin
              stored_line <= stored_line + 1'b1;
              line_base   <= line_base + LINE_STEP;
            end
          end
        end
      end
      if (frame_end) begin
        frame_done_q <= 1'b1;
        short_q      <= (wr_count < TOTAL);
      end
    end
  end

  assign bus.we      = we_q;
  assign bus.waddr   = waddr_q;
  assign bus.wdata   = wdata_q;
  assign frame_done  = frame_done_q;
  assign short_frame = short_q;
  assign busy        = (state == WAIT_VS) || (state == WAIT_ACT) || (state == CAPTURE);
endmodule
